pic_write_sequencer: RTL and testbench



---
 rtl/pic_write_sequencer_pkg.sv | 35 +++
 rtl/pic_write_sequencer_if.sv | 18 +
 rtl/pic_write_sequencer_bus_write_capture.sv | 59 +++++
 rtl/pic_write_sequencer.sv | 128 ++++++++++++
 tb/tb_pic_write_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pic_write_sequencer_pkg.sv
// pic_pkg: shared types and constants for the 8259A PIC write path.
//   seq_state_t      - initialisation sequencer states
//   *_BIT constants  - bit positions inside ICWs_Flags / OCWs_Flags
//   D4_SEL, D3_SEL   - command-select bits of an A0=0 write byte
//   SNGL_BIT/IC4_BIT - ICW1 option bits
package pic_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    ST_UNINIT,
    ST_WAIT_ICW2,
    ST_WAIT_ICW3,
    ST_WAIT_ICW4,
    ST_READY
  } seq_state_t;

  // ICWs_Flags bit positions
  localparam int unsigned ICW1_BIT = 0;
  localparam int unsigned ICW2_BIT = 1;
  localparam int unsigned ICW3_BIT = 2;
  localparam int unsigned ICW4_BIT = 3;

  // OCWs_Flags bit positions
  localparam int unsigned OCW1_BIT = 0;
  localparam int unsigned OCW2_BIT = 1;
  localparam int unsigned OCW3_BIT = 2;

  // Decode bit positions within the written byte
  localparam int unsigned D4_SEL   = 4;
  localparam int unsigned D3_SEL   = 3;
  localparam int unsigned SNGL_BIT = 1;
  localparam int unsigned IC4_BIT  = 0;

endpackage

// File: rtl/pic_write_sequencer_if.sv
// pic_write_sequencer_if: CPU write bus seen by the PIC.
//   CS_n    - chip select, active low
//   WR_n    - write strobe, active low; write completes on its rising edge
//   A0      - register address bit
//   DATA_IN - write data
// modport master drives the bus (CPU side), modport slave receives it (PIC).
interface pic_write_sequencer_if;
  import pic_pkg::*;

  logic              CS_n;
  logic              WR_n;
  logic              A0;
  logic [DATA_W-1:0] DATA_IN;

  modport master (output CS_n, output WR_n, output A0, output DATA_IN);
  modport slave  (input  CS_n, input  WR_n, input  A0, input  DATA_IN);

endinterface

// File: rtl/pic_write_sequencer_bus_write_capture.sv
// bus_write_capture: samples the CPU write bus and produces one write event
// per completed write.
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_cs_n      - chip select, active low
//   i_wr_n      - write strobe, active low
//   i_a0        - address bit
//   i_data      - write data
//   o_wr_event  - combinational, high on the edge that samples WR_n rising
//                 after a valid captured low phase
//   o_wr_a0     - captured A0 of the completing write
//   o_wr_data   - captured data of the completing write
module bus_write_capture
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cs_n,
  input  logic              i_wr_n,
  input  logic              i_a0,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_wr_event,
  output logic              o_wr_a0,
  output logic [DATA_W-1:0] o_wr_data
);

  logic              r_a0;
  logic [DATA_W-1:0] r_data;
  logic              r_cap_valid;
  logic              r_wr_prev;
  logic              w_event;

  assign w_event = i_wr_n & ~r_wr_prev & r_cap_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a0        <= 1'b0;
      r_data      <= '0;
      r_cap_valid <= 1'b0;
      r_wr_prev   <= 1'b1;
    end else begin
      r_wr_prev <= i_wr_n;
      if (!i_cs_n && !i_wr_n) begin
        r_a0        <= i_a0;
        r_data      <= i_data;
        r_cap_valid <= 1'b1;
      end else if (i_cs_n && !i_wr_n) begin
        // deselect during the low phase aborts the pending write
        r_cap_valid <= 1'b0;
      end else if (w_event) begin
        r_cap_valid <= 1'b0;
      end
    end
  end

  assign o_wr_event = w_event;
  assign o_wr_a0    = r_a0;
  assign o_wr_data  = r_data;

endmodule

// File: rtl/pic_write_sequencer.sv
// pic_write_sequencer: CPU write-path front end of the 8259A PIC.
// Decodes completed bus writes into ICW/OCW one-cycle pulses and runs the
// ICW1 -> ICW2 -> [ICW3] -> [ICW4] initialisation sequence.
//   clk, rst_n  - clock, asynchronous active-low reset
//   cpu_bus     - CPU write bus (CS_n, WR_n, A0, DATA_IN), slave modport
//   DATA_OUT    - last accepted write byte, held
//   ICWs_Flags  - one-hot pulse: ICW1..ICW4
//   OCWs_Flags  - one-hot pulse: OCW1..OCW3
//   init_done   - high while the sequencer is READY
//   SNGL, IC4   - ICW1 option bits latched at ICW1
module pic_write_sequencer
  import pic_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  pic_write_sequencer_if.slave cpu_bus,
  output logic [DATA_W-1:0]  DATA_OUT,
  output logic [3:0]         ICWs_Flags,
  output logic [2:0]         OCWs_Flags,
  output logic               init_done,
  output logic               SNGL,
  output logic               IC4
);

  logic              w_wr_event;
  logic              w_wr_a0;
  logic [DATA_W-1:0] w_wr_data;

  seq_state_t        r_state;
  seq_state_t        w_next_state;
  logic [3:0]        r_icw;
  logic [3:0]        w_icw;
  logic [2:0]        r_ocw;
  logic [2:0]        w_ocw;
  logic [DATA_W-1:0] r_data_out;
  logic [DATA_W-1:0] w_data_out;
  logic              r_sngl;
  logic              w_sngl;
  logic              r_ic4;
  logic              w_ic4;

  bus_write_capture u_capture (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cs_n     (cpu_bus.CS_n),
    .i_wr_n     (cpu_bus.WR_n),
    .i_a0       (cpu_bus.A0),
    .i_data     (cpu_bus.DATA_IN),
    .o_wr_event (w_wr_event),
    .o_wr_a0    (w_wr_a0),
    .o_wr_data  (w_wr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_UNINIT;
      r_icw      <= '0;
      r_ocw      <= '0;
      r_data_out <= '0;
      r_sngl     <= 1'b0;
      r_ic4      <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_icw      <= w_icw;
      r_ocw      <= w_ocw;
      r_data_out <= w_data_out;
      r_sngl     <= w_sngl;
      r_ic4      <= w_ic4;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_icw        = '0;
    w_ocw        = '0;
    w_data_out   = r_data_out;
    w_sngl       = r_sngl;
    w_ic4        = r_ic4;

    if (w_wr_event) begin
      if (!w_wr_a0 && w_wr_data[D4_SEL]) begin
        // ICW1 is honoured in every state and restarts the sequence
        w_icw[ICW1_BIT] = 1'b1;
        w_data_out      = w_wr_data;
        w_sngl          = w_wr_data[SNGL_BIT];
        w_ic4           = w_wr_data[IC4_BIT];
        w_next_state    = ST_WAIT_ICW2;
      end else if (w_wr_a0) begin
        unique case (r_state)
          ST_WAIT_ICW2: begin
            w_icw[ICW2_BIT] = 1'b1;
            w_data_out      = w_wr_data;
            if (!r_sngl)     w_next_state = ST_WAIT_ICW3;
            else if (r_ic4)  w_next_state = ST_WAIT_ICW4;
            else             w_next_state = ST_READY;
          end
          ST_WAIT_ICW3: begin
            w_icw[ICW3_BIT] = 1'b1;
            w_data_out      = w_wr_data;
            w_next_state    = r_ic4 ? ST_WAIT_ICW4 : ST_READY;
          end
          ST_WAIT_ICW4: begin
            w_icw[ICW4_BIT] = 1'b1;
            w_data_out      = w_wr_data;
            w_next_state    = ST_READY;
          end
          ST_READY: begin
            w_ocw[OCW1_BIT] = 1'b1;
            w_data_out      = w_wr_data;
          end
          default: ;
        endcase
      end else if (r_state == ST_READY) begin
        if (w_wr_data[D3_SEL]) w_ocw[OCW3_BIT] = 1'b1;
        else                   w_ocw[OCW2_BIT] = 1'b1;
        w_data_out = w_wr_data;
      end
    end
  end

  assign DATA_OUT   = r_data_out;
  assign ICWs_Flags = r_icw;
  assign OCWs_Flags = r_ocw;
  assign init_done  = (r_state == ST_READY);
  assign SNGL       = r_sngl;
  assign IC4        = r_ic4;

endmodule

// File: tb/tb_pic_write_sequencer.sv
module tb_pic_write_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] DATA_OUT;
  logic [3:0] ICWs_Flags;
  logic [2:0] OCWs_Flags;
  logic       init_done;
  logic       SNGL;
  logic       IC4;

  pic_write_sequencer_if bus_if ();

  pic_write_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_bus    (bus_if),
    .DATA_OUT   (DATA_OUT),
    .ICWs_Flags (ICWs_Flags),
    .OCWs_Flags (OCWs_Flags),
    .init_done  (init_done),
    .SNGL       (SNGL),
    .IC4        (IC4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: initialisation progress kept as a queue of the ICW
  // numbers still owed after ICW1.
  logic [7:0] m_data;
  logic       m_sngl, m_ic4, m_started;
  logic [3:0] m_icw;
  logic [2:0] m_ocw;
  int         m_pending[$];

  function automatic void model_reset();
    m_data = 8'h00; m_sngl = 1'b0; m_ic4 = 1'b0; m_started = 1'b0;
    m_icw = 4'h0; m_ocw = 3'h0;
    m_pending.delete();
  endfunction

  function automatic bit model_ready();
    return m_started && (m_pending.size() == 0);
  endfunction

  function automatic void model_write(input logic a0, input logic [7:0] d);
    int n;
    m_icw = 4'h0;
    m_ocw = 3'h0;
    if (!a0 && d[4]) begin
      m_started = 1'b1;
      m_sngl = d[1];
      m_ic4  = d[0];
      m_pending.delete();
      m_pending.push_back(2);
      if (!d[1]) m_pending.push_back(3);
      if (d[0])  m_pending.push_back(4);
      m_icw  = 4'b0001;
      m_data = d;
    end else if (a0) begin
      if (m_started) begin
        if (m_pending.size() > 0) begin
          n = m_pending.pop_front();
          m_icw = 4'(1 << (n - 1));
        end else begin
          m_ocw = 3'b001;
        end
        m_data = d;
      end
    end else if (model_ready()) begin
      m_ocw  = d[3] ? 3'b100 : 3'b010;
      m_data = d;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] eicw, input logic [2:0] eocw);
    chk({tag, ".icw"},  32'(ICWs_Flags), 32'(eicw));
    chk({tag, ".ocw"},  32'(OCWs_Flags), 32'(eocw));
    chk({tag, ".data"}, 32'(DATA_OUT),   32'(m_data));
    chk({tag, ".init"}, 32'(init_done),  32'(model_ready()));
    chk({tag, ".sngl"}, 32'(SNGL),       32'(m_sngl));
    chk({tag, ".ic4"},  32'(IC4),        32'(m_ic4));
  endtask

  // Called and returns at a negedge.
  task automatic do_write(input logic a0, input logic [7:0] d, input int low,
                          input int gap, input string tag);
    bus_if.CS_n = 1'b0; bus_if.WR_n = 1'b0; bus_if.A0 = a0; bus_if.DATA_IN = d;
    repeat (low) begin
      @(posedge clk); #1;
      check_all({tag, ".low"}, 4'h0, 3'h0);
      @(negedge clk);
    end
    bus_if.WR_n = 1'b1;
    model_write(a0, d);
    @(posedge clk); #1;
    check_all(tag, m_icw, m_ocw);
    @(negedge clk);
    bus_if.CS_n = 1'b1;
    bus_if.DATA_IN = 8'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
      check_all({tag, ".idle"}, 4'h0, 3'h0);
      @(negedge clk);
    end
  endtask

  task automatic do_abort(input string tag);
    bus_if.CS_n = 1'b0; bus_if.WR_n = 1'b0;
    bus_if.A0 = 1'($urandom); bus_if.DATA_IN = 8'($urandom) | 8'h10;
    @(posedge clk); #1; check_all({tag, ".cap"}, 4'h0, 3'h0);
    @(negedge clk); bus_if.CS_n = 1'b1;
    @(posedge clk); #1; check_all({tag, ".desel"}, 4'h0, 3'h0);
    @(negedge clk); bus_if.WR_n = 1'b1;
    @(posedge clk); #1; check_all({tag, ".rise"}, 4'h0, 3'h0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a0;
    logic [7:0] d;
    int         r;

    model_reset();
    rst_n = 1'b0;
    bus_if.CS_n = 1'b1; bus_if.WR_n = 1'b1; bus_if.A0 = 1'b0; bus_if.DATA_IN = 8'h00;
    repeat (3) @(negedge clk);
    check_all("reset", 4'h0, 3'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Writes before ICW1 are ignored
    do_write(1'b1, 8'h55, 1, 1, "preinit_a1");
    do_write(1'b0, 8'h20, 2, 1, "preinit_a0");

    // Cascade mode, no ICW4
    do_write(1'b0, 8'h10, 1, 0, "full_icw1");
    do_write(1'b1, 8'h20, 1, 0, "full_icw2");
    do_write(1'b1, 8'h04, 1, 1, "full_icw3");
    chk("full_ready", 32'(init_done), 32'd1);

    // OCWs in READY
    do_write(1'b1, 8'hAA, 1, 0, "ocw1");
    do_write(1'b0, 8'h20, 1, 0, "ocw2");
    do_write(1'b0, 8'h0B, 1, 1, "ocw3");

    // Single mode with ICW4
    do_write(1'b0, 8'h13, 2, 0, "sgl_icw1");
    do_write(1'b1, 8'h08, 1, 0, "sgl_icw2");
    do_write(1'b1, 8'h01, 1, 1, "sgl_icw4");
    chk("sgl_ready", 32'(init_done), 32'd1);

    // Restart from WAIT_ICW3
    do_write(1'b0, 8'h10, 1, 1, "rst_icw1a");
    do_write(1'b1, 8'h22, 1, 1, "rst_icw2a");
    do_write(1'b0, 8'h12, 1, 1, "rst_icw1b");
    do_write(1'b1, 8'h30, 1, 1, "rst_icw2b");

    // Deselect aborts a write
    do_abort("abort");

    // Reset while a write is in its low phase in WAIT_ICW4
    do_write(1'b0, 8'h13, 1, 1, "mid_icw1");
    do_write(1'b1, 8'h08, 1, 1, "mid_icw2");
    bus_if.CS_n = 1'b0; bus_if.WR_n = 1'b0; bus_if.A0 = 1'b1; bus_if.DATA_IN = 8'h01;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.CS_n = 1'b1;
    model_reset();
    #1; check_all("midrst", 4'h0, 3'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; check_all("midrst.rel", 4'h0, 3'h0);
    @(negedge clk); bus_if.WR_n = 1'b1;
    @(posedge clk); #1; check_all("midrst.rise", 4'h0, 3'h0);
    @(negedge clk);
    do_write(1'b1, 8'h77, 1, 1, "midrst.a1");

    // Write held low across reset release starts a fresh capture
    rst_n = 1'b0;
    bus_if.CS_n = 1'b0; bus_if.WR_n = 1'b0; bus_if.A0 = 1'b0; bus_if.DATA_IN = 8'h11;
    @(negedge clk); rst_n = 1'b1;
    do_write(1'b0, 8'h11, 1, 1, "across_rel");

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do_abort("rnd_abort");
      end else begin
        if (r == 1) begin
          a0 = 1'b0;
          d  = 8'($urandom) | 8'h10;
        end else begin
          a0 = 1'($urandom);
          d  = 8'($urandom);
          if (!a0) d[4] = 1'b0;
        end
        do_write(a0, d, $urandom_range(1, 3), $urandom_range(0, 2), "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
